bitcoin_nonce_scanner: RTL and testbench
========================================

# bitcoin_nonce_scanner

Downstream stage of the Bitcoin nonce-search hash block. Once the hash block has written one H0 word per nonce to shared memory, this block reads those words back and compares each against a 32-bit difficulty target. It records the hit count, the first winning nonce and (optionally) the minimum hash, then writes a summary record back to memory. It uses the same single-port synchronous memory interface as the hash block.

## Interface
- `NUM_NONCES`, default 16: number of consecutive H0 words scanned; legal range 1..255.
- `clk` input, 1 bit: clock.
- `reset_n` input, 1 bit: reset, asynchronous, active-low.
- `start` input, 1 bit: begin a scan; sampled only in IDLE.
- `hash_addr` input, 16 bits: base address of the H0 words; nonce i is at `hash_addr+i`.
- `result_addr` input, 16 bits: base address of the summary record.
- `target` input, 32 bits: difficulty threshold, unsigned; latched at start.
- `done` output, 1 bit: high exactly while in IDLE.
- `mem_clk` output, 1 bit: equals `clk`.
- `mem_we` output, 1 bit: write enable.
- `mem_addr` output, 16 bits: memory address.
- `mem_write_data` output, 32 bits: write data.
- `mem_read_data` input, 32 bits: read data, valid the cycle after the address is presented.
- `found` output, 1 bit: at least one hit in the last scan.
- `hit_count` output, 8 bits: number of hits.
- `first_nonce` output, 8 bits: lowest hitting nonce index; 0 if none.
- `min_hash` output, 32 bits: smallest H0 seen (`NONCE_SCAN_MIN_TRACK_EN` only).
- `min_nonce` output, 8 bits: nonce index of `min_hash` (`NONCE_SCAN_MIN_TRACK_EN` only).

## Operation
- States: IDLE, RD, CMP, WR0, WR1.
- **IDLE**
  - On `start`: latch `target`, `hash_addr` and `result_addr`; clear the index, `found`, `hit_count` and `first_nonce`.
  - Set `min_hash` to 32'hFFFFFFFF and `min_nonce` to 0.
  - Go to RD.
- **RD**: `mem_addr = hash_addr_q + i`, `mem_we = 0`; go to CMP.
- **CMP** (`mem_read_data` valid in this state)
  - Hit rule: `mem_read_data < target_q`, strict unsigned compare.
  - On a hit: increment `hit_count`. If `found` was 0, set `found = 1` and `first_nonce = i`.
  - Min rule: if `mem_read_data < min_hash`, update `min_hash` and `min_nonce`. The compare is strict, so on a tie the lowest nonce is kept.
  - If `i == NUM_NONCES-1`, go to WR0; otherwise increment `i` and go to RD.
- **WR0**
  - `mem_we = 1`, `mem_addr = result_addr_q`.
  - `mem_write_data = {found, 7'b0, hit_count, 8'b0, first_nonce}`.
  - Next state: WR1 if min tracking is compiled in, else IDLE.
- **WR1**: `mem_we = 1`, `mem_addr = result_addr_q+1`, `mem_write_data = min_hash`; go to IDLE.
- `mem_addr`, `mem_we` and `mem_write_data` are combinational from state and registers. Outside the WR states, `mem_we = 0` and `mem_write_data = 0`.
- Result outputs hold their values from the last scan until the next `start` is accepted.
- `start` outside IDLE is ignored; `target` and the address inputs may change freely once the scan is running.
- If `start` is held high continuously, a new scan begins on the cycle `done` is high; each scan completes normally.

## Timing
- Reset values:
  - state IDLE, `done` 1, `mem_we` 0, `mem_addr` 0, `mem_write_data` 0.
  - `found` 0, `hit_count` 0, `first_nonce` 0, `min_hash` 32'hFFFFFFFF, `min_nonce` 0.
- Each nonce takes 2 cycles (RD then CMP).
- `done` is low for exactly `2*NUM_NONCES+2` cycles after the start-sampling edge with min tracking, `2*NUM_NONCES+1` without. Default: 34 / 33.
- Final result outputs are valid from the cycle `done` rises. WR0 already uses the registers updated by the last CMP.
- Reset mid-scan returns the block to IDLE immediately and restores all reset values. A partial summary is never written.
- `hit_count` cannot overflow, because `NUM_NONCES` is at most 255.

## Configuration
- `NONCE_SCAN_MIN_TRACK_EN` defined:
  - `min_hash`/`min_nonce` registers and ports exist.
  - WR1 is present; two summary words are written.
- Not defined:
  - Those ports, registers and WR1 are removed.
  - WR0 returns to IDLE; one summary word is written; latency is reduced by 1 cycle.

## Test plan
- **All above target**: `NUM_NONCES`=16, every H0 = 32'h8000_0000, target 32'h0001_0000. Expect word0 = 0, `found` = 0; with the EN macro, word1 = 32'h8000_0000 and `min_nonce` = 0.
- **Three hits**: H0 at nonces 3, 7, 12 equal to 32'h0000_0010, others 32'hFFFF_0000, target 32'h0000_0100. Expect word0 = 32'h8003_0003 and `min_nonce` = 3 (tie resolved to the lowest nonce).
- **Strict compare**: target 32'h0000_0010 with the same data. Expect no hits, word0 = 0, `min_hash` = 32'h0000_0010.
- **Latency and protocol**: count `done`-low cycles (expect 34 with EN, 33 without). Check `mem_we` is high only in the final 2 (or 1) cycles at `result_addr`/`result_addr+1`, and that RD addresses step `hash_addr`..`hash_addr+15`.
- **Reset mid-scan**: assert `reset_n` low during the 9th CMP. Expect `done` = 1 immediately, no memory write, all outputs at reset values; a following scan produces correct results.
- **Start ignored while busy**: pulse `start` again with a different `result_addr` mid-scan. The summary must land at the original `result_addr`.

Source files
------------

// File: rtl/bitcoin_nonce_scanner.sv
// Scans NUM_NONCES H0 words from memory against a difficulty target and writes a summary record.
// Optional min-hash tracking (extra summary word, min_hash/min_nonce ports) under NONCE_SCAN_MIN_TRACK_EN.
module bitcoin_nonce_scanner #(
    parameter int NUM_NONCES = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] hash_addr,
    input  logic [15:0] result_addr,
    input  logic [31:0] target,
    output logic        done,
    output logic        mem_clk,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data,
    output logic        found,
    output logic [7:0]  hit_count,
    output logic [7:0]  first_nonce
`ifdef NONCE_SCAN_MIN_TRACK_EN
    ,
    output logic [31:0] min_hash,
    output logic [7:0]  min_nonce
`endif
);

    localparam logic [7:0] LAST_IDX = 8'(NUM_NONCES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_CMP,
        S_WR0
`ifdef NONCE_SCAN_MIN_TRACK_EN
        ,
        S_WR1
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  idx_q, idx_d;
    logic [31:0] target_q, target_d;
    logic [15:0] hash_addr_q, hash_addr_d;
    logic [15:0] result_addr_q, result_addr_d;
    logic        found_q, found_d;
    logic [7:0]  hit_count_q, hit_count_d;
    logic [7:0]  first_nonce_q, first_nonce_d;
`ifdef NONCE_SCAN_MIN_TRACK_EN
    logic [31:0] min_hash_q, min_hash_d;
    logic [7:0]  min_nonce_q, min_nonce_d;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            target_q      <= '0;
            hash_addr_q   <= '0;
            result_addr_q <= '0;
            found_q       <= 1'b0;
            hit_count_q   <= '0;
            first_nonce_q <= '0;
`ifdef NONCE_SCAN_MIN_TRACK_EN
            min_hash_q    <= 32'hFFFF_FFFF;
            min_nonce_q   <= '0;
`endif
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            target_q      <= target_d;
            hash_addr_q   <= hash_addr_d;
            result_addr_q <= result_addr_d;
            found_q       <= found_d;
            hit_count_q   <= hit_count_d;
            first_nonce_q <= first_nonce_d;
`ifdef NONCE_SCAN_MIN_TRACK_EN
            min_hash_q    <= min_hash_d;
            min_nonce_q   <= min_nonce_d;
`endif
        end
    end

    // Memory outputs are purely combinational so the summary write sees the last CMP's results.
    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        target_d       = target_q;
        hash_addr_d    = hash_addr_q;
        result_addr_d  = result_addr_q;
        found_d        = found_q;
        hit_count_d    = hit_count_q;
        first_nonce_d  = first_nonce_q;
`ifdef NONCE_SCAN_MIN_TRACK_EN
        min_hash_d     = min_hash_q;
        min_nonce_d    = min_nonce_q;
`endif
        mem_we         = 1'b0;
        mem_addr       = '0;
        mem_write_data = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    target_d      = target;
                    hash_addr_d   = hash_addr;
                    result_addr_d = result_addr;
                    idx_d         = '0;
                    found_d       = 1'b0;
                    hit_count_d   = '0;
                    first_nonce_d = '0;
`ifdef NONCE_SCAN_MIN_TRACK_EN
                    min_hash_d    = 32'hFFFF_FFFF;
                    min_nonce_d   = '0;
`endif
                    state_d       = S_RD;
                end
            end
            S_RD: begin
                mem_addr = hash_addr_q + {8'h00, idx_q};
                state_d  = S_CMP;
            end
            S_CMP: begin
                if (mem_read_data < target_q) begin
                    hit_count_d = hit_count_q + 8'd1;
                    if (!found_q) begin
                        found_d       = 1'b1;
                        first_nonce_d = idx_q;
                    end
                end
`ifdef NONCE_SCAN_MIN_TRACK_EN
                // Strict compare keeps the lowest nonce on ties.
                if (mem_read_data < min_hash_q) begin
                    min_hash_d  = mem_read_data;
                    min_nonce_d = idx_q;
                end
`endif
                if (idx_q == LAST_IDX) begin
                    state_d = S_WR0;
                end else begin
                    idx_d   = idx_q + 8'd1;
                    state_d = S_RD;
                end
            end
            S_WR0: begin
                mem_we         = 1'b1;
                mem_addr       = result_addr_q;
                mem_write_data = {found_q, 7'b0, hit_count_q, 8'b0, first_nonce_q};
`ifdef NONCE_SCAN_MIN_TRACK_EN
                state_d        = S_WR1;
`else
                state_d        = S_IDLE;
`endif
            end
`ifdef NONCE_SCAN_MIN_TRACK_EN
            S_WR1: begin
                mem_we         = 1'b1;
                mem_addr       = result_addr_q + 16'd1;
                mem_write_data = min_hash_q;
                state_d        = S_IDLE;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    assign done        = (state_q == S_IDLE);
    assign mem_clk     = clk;
    assign found       = found_q;
    assign hit_count   = hit_count_q;
    assign first_nonce = first_nonce_q;
`ifdef NONCE_SCAN_MIN_TRACK_EN
    assign min_hash    = min_hash_q;
    assign min_nonce   = min_nonce_q;
`endif

endmodule

// File: tb/tb_bitcoin_nonce_scanner.sv
// Self-checking bench for bitcoin_nonce_scanner: table-driven scans plus reset-mid-scan and busy-start sequences.
// Honours NONCE_SCAN_MIN_TRACK_EN the same way as the design.
module tb_bitcoin_nonce_scanner;

    localparam int N = 16;
`ifdef NONCE_SCAN_MIN_TRACK_EN
    localparam int LAT = 2 * N + 2;
`else
    localparam int LAT = 2 * N + 1;
`endif
    localparam logic [15:0] RES = 16'h00A0;
    localparam logic [15:0] ALT = 16'h00C0;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [15:0] hash_addr;
    logic [15:0] result_addr;
    logic [31:0] target;
    logic        done;
    logic        mem_clk;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    logic        found;
    logic [7:0]  hit_count;
    logic [7:0]  first_nonce;
`ifdef NONCE_SCAN_MIN_TRACK_EN
    logic [31:0] min_hash;
    logic [7:0]  min_nonce;
`endif

    int errors = 0;
    int checks = 0;

    logic [31:0] h0_mem  [0:255];
    logic [31:0] wr_data [0:255];
    logic        wr_seen [0:255];
    logic [31:0] rd_q;
    logic        clear_log = 1'b0;

    always #5 clk = ~clk;

    bitcoin_nonce_scanner #(.NUM_NONCES(N)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .start(start),
        .hash_addr(hash_addr),
        .result_addr(result_addr),
        .target(target),
        .done(done),
        .mem_clk(mem_clk),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data),
        .found(found),
        .hit_count(hit_count),
        .first_nonce(first_nonce)
`ifdef NONCE_SCAN_MIN_TRACK_EN
        ,
        .min_hash(min_hash),
        .min_nonce(min_nonce)
`endif
    );

    // Single-port synchronous memory: read data one cycle after the address; writes are logged.
    always @(posedge mem_clk) begin
        rd_q <= h0_mem[mem_addr[7:0]];
        if (clear_log) begin
            for (int a = 0; a < 256; a++) wr_seen[a] <= 1'b0;
        end else if (mem_we) begin
            wr_seen[mem_addr[7:0]] <= 1'b1;
            wr_data[mem_addr[7:0]] <= mem_write_data;
        end
    end
    assign mem_read_data = rd_q;

    typedef struct {
        logic [15:0] mask;
        logic [31:0] hit_val;
        logic [31:0] miss_val;
        logic [31:0] tgt;
        logic [31:0] exp_word0;
        logic [31:0] exp_min_hash;
        logic [7:0]  exp_min_nonce;
    } vec_t;

    vec_t vec [0:5];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic loadAndClear(input int v, input logic [15:0] base);
        for (int i = 0; i < N; i++)
            h0_mem[base[7:0] + 8'(i)] = vec[v].mask[i] ? vec[v].hit_val : vec[v].miss_val;
        @(negedge clk);
        clear_log = 1'b1;
        @(negedge clk);
        clear_log = 1'b0;
    endtask

    task automatic checkResults(input int v);
        checkOutput("found", {31'b0, found}, {31'b0, vec[v].exp_word0[31]});
        checkOutput("hit_count", {24'b0, hit_count}, {24'b0, vec[v].exp_word0[23:16]});
        checkOutput("first_nonce", {24'b0, first_nonce}, {24'b0, vec[v].exp_word0[7:0]});
        checkOutput("word0_written", {31'b0, wr_seen[RES[7:0]]}, 32'd1);
        checkOutput("word0", wr_data[RES[7:0]], vec[v].exp_word0);
`ifdef NONCE_SCAN_MIN_TRACK_EN
        checkOutput("word1", wr_data[RES[7:0] + 8'd1], vec[v].exp_min_hash);
        checkOutput("min_hash", min_hash, vec[v].exp_min_hash);
        checkOutput("min_nonce", {24'b0, min_nonce}, {24'b0, vec[v].exp_min_nonce});
`else
        checkOutput("word1_absent", {31'b0, wr_seen[RES[7:0] + 8'd1]}, 32'd0);
`endif
    endtask

    // Runs one full scan of vector v, checking latency and per-cycle memory protocol.
    task automatic applyStimulus(input int v, input bit glitch);
        logic [15:0] base;
        int k;
        int guard;
        int prot_err;
        base = 16'(16 + 16 * v);
        loadAndClear(v, base);
        guard = 0;
        while (!done && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("idle_before_start", {31'b0, done}, 32'd1);
        hash_addr   = base;
        result_addr = RES;
        target      = vec[v].tgt;
        start       = 1'b1;
        @(negedge clk);
        k = 0;
        prot_err = 0;
        while (k < 200 && !done) begin
            if (glitch && k == 5) begin
                start       = 1'b1;
                result_addr = ALT;
                hash_addr   = 16'h00F0;
                target      = 32'hFFFF_FFFF;
            end else begin
                start = 1'b0;
            end
            if (k < 2 * N) begin
                if (mem_we !== 1'b0) prot_err++;
                if ((k % 2) == 0 && mem_addr !== base + 16'(k / 2)) prot_err++;
            end else if (k == 2 * N) begin
                if (mem_we !== 1'b1 || mem_addr !== RES) prot_err++;
            end else begin
                if (mem_we !== 1'b1 || mem_addr !== RES + 16'd1) prot_err++;
            end
            k++;
            @(negedge clk);
        end
        start = 1'b0;
        checkOutput("latency", k, LAT);
        checkOutput("protocol_errors", prot_err, 0);
        checkOutput("idle_mem_we", {31'b0, mem_we}, 32'd0);
        checkResults(v);
        if (glitch) checkOutput("alt_addr_untouched", {31'b0, wr_seen[ALT[7:0]]}, 32'd0);
    endtask

    task automatic checkResetValues();
        checkOutput("rst_done", {31'b0, done}, 32'd1);
        checkOutput("rst_mem_we", {31'b0, mem_we}, 32'd0);
        checkOutput("rst_mem_addr", {16'b0, mem_addr}, 32'd0);
        checkOutput("rst_mem_write_data", mem_write_data, 32'd0);
        checkOutput("rst_found", {31'b0, found}, 32'd0);
        checkOutput("rst_hit_count", {24'b0, hit_count}, 32'd0);
        checkOutput("rst_first_nonce", {24'b0, first_nonce}, 32'd0);
`ifdef NONCE_SCAN_MIN_TRACK_EN
        checkOutput("rst_min_hash", min_hash, 32'hFFFF_FFFF);
        checkOutput("rst_min_nonce", {24'b0, min_nonce}, 32'd0);
`endif
    endtask

    // Starts vector 1 and pulls reset during the 9th CMP cycle.
    task automatic resetMidScan();
        logic [15:0] base;
        base = 16'(16 + 16 * 1);
        loadAndClear(1, base);
        hash_addr   = base;
        result_addr = RES;
        target      = vec[1].tgt;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 17; k++) @(negedge clk);
        reset_n = 1'b0;
        #1;
        checkResetValues();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("no_partial_summary", {31'b0, wr_seen[RES[7:0]]}, 32'd0);
    endtask

    initial begin
        vec[0] = '{mask: 16'h0000, hit_val: 32'h0, miss_val: 32'h8000_0000, tgt: 32'h0001_0000,
                   exp_word0: 32'h0000_0000, exp_min_hash: 32'h8000_0000, exp_min_nonce: 8'd0};
        vec[1] = '{mask: 16'h1088, hit_val: 32'h0000_0010, miss_val: 32'hFFFF_0000, tgt: 32'h0000_0100,
                   exp_word0: 32'h8003_0003, exp_min_hash: 32'h0000_0010, exp_min_nonce: 8'd3};
        vec[2] = '{mask: 16'h1088, hit_val: 32'h0000_0010, miss_val: 32'hFFFF_0000, tgt: 32'h0000_0010,
                   exp_word0: 32'h0000_0000, exp_min_hash: 32'h0000_0010, exp_min_nonce: 8'd3};
        vec[3] = '{mask: 16'h8001, hit_val: 32'h0000_0000, miss_val: 32'h1234_5678, tgt: 32'h0000_0001,
                   exp_word0: 32'h8002_0000, exp_min_hash: 32'h0000_0000, exp_min_nonce: 8'd0};
        vec[4] = '{mask: 16'h8000, hit_val: 32'hFFFF_FFFE, miss_val: 32'hFFFF_FFFF, tgt: 32'hFFFF_FFFF,
                   exp_word0: 32'h8001_000F, exp_min_hash: 32'hFFFF_FFFE, exp_min_nonce: 8'd15};
        vec[5] = '{mask: 16'hFFFF, hit_val: 32'h0000_0005, miss_val: 32'h0000_0000, tgt: 32'h0000_0006,
                   exp_word0: 32'h8010_0000, exp_min_hash: 32'h0000_0005, exp_min_nonce: 8'd0};

        reset_n     = 1'b0;
        start       = 1'b0;
        hash_addr   = '0;
        result_addr = '0;
        target      = '0;
        repeat (3) @(negedge clk);
        checkResetValues();
        reset_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            $display("[TB] scan vector %0d", v);
            applyStimulus(v, 1'b0);
        end

        $display("[TB] start pulse while busy");
        applyStimulus(1, 1'b1);

        $display("[TB] reset mid-scan");
        resetMidScan();
        applyStimulus(1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
